edge_pulse_generator_stacked: RTL and testbench

Programmable pulse-train source that drives the odometer edge-detection input path: emits rising edges that the stacked edge detector must register exactly once each. It guarantees the detector's rising-edge precondition: at least two consecutive low samples before every high. It is used both as an on-chip stimulus for the odometer counters and as a self-test source. START/STOP control, a BUSY/DONE status pair, and a pulse counter for cross-checking detector counts.

---
 rtl/edge_pulse_generator_stacked_pkg.sv | 14 +
 rtl/edge_pulse_generator_stacked_phase_down_counter.sv | 34 +++
 rtl/edge_pulse_generator_stacked.sv | 162 ++++++++++++++++
 tb/tb_edge_pulse_generator_stacked.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/edge_pulse_generator_stacked_pkg.sv
// rtl/edge_pulse_generator_stacked_pkg.sv - shared odometer state encoding and low-phase default
package edge_pulse_generator_stacked_pkg;

  localparam int MIN_LOW_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_GUARD = 3'd3,
    ST_FIN   = 3'd4
  } epg_state_e;

endpackage

// File: rtl/edge_pulse_generator_stacked_phase_down_counter.sv
// rtl/edge_pulse_generator_stacked_phase_down_counter.sv - loadable down-counter with zero flag for phase timing
module edge_pulse_generator_stacked_phase_down_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/edge_pulse_generator_stacked.sv
// rtl/edge_pulse_generator_stacked.sv - programmable pulse-train source for the stacked edge detector
module edge_pulse_generator_stacked
  import edge_pulse_generator_stacked_pkg::*;
#(
  parameter int CW      = 8,
  parameter int PCW     = 16,
  parameter int MIN_LOW = MIN_LOW_DEFAULT
) (
  input  logic           CLK,
  input  logic           RESETB,
  input  logic           START,
  input  logic           STOP,
  input  logic [CW-1:0]  HIGH_CYC,
  input  logic [CW-1:0]  LOW_CYC,
  input  logic [CW-1:0]  NUM_PULSES,
  output logic           OUT,
  output logic           BUSY,
  output logic           DONE,
  output logic [PCW-1:0] PULSE_CNT
);

  localparam logic [CW-1:0] ONE_W     = CW'(1);
  localparam logic [CW-1:0] MIN_LOW_W = CW'(MIN_LOW);
  localparam logic [CW-1:0] SAT_W     = {CW{1'b1}};

  epg_state_e     state_q, state_d;
  logic [CW-1:0]  h_q, h_d, l_q, l_d, n_q, n_d;
  logic [CW-1:0]  burst_q, burst_d;
  logic [CW-1:0]  low_run_q, low_run_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]  h_clamp, l_clamp;
  logic           cnt_load;
  logic [CW-1:0]  cnt_val;
  logic           cnt_zero;

  edge_pulse_generator_stacked_phase_down_counter #(.CW(CW)) u_phase_cnt (
    .clk      (CLK),
    .rst_n    (RESETB),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    l_d       = l_q;
    n_d       = n_q;
    burst_d   = burst_q;
    pcnt_d    = pcnt_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    h_clamp   = (HIGH_CYC == '0) ? ONE_W : HIGH_CYC;
    l_clamp   = (LOW_CYC < MIN_LOW_W) ? MIN_LOW_W : LOW_CYC;
    // Consecutive low cycles seen on OUT, saturating; gates the first rise after reset
    low_run_d = low_run_q;
    if (out_q) begin
      low_run_d = '0;
    end else if (low_run_q < MIN_LOW_W) begin
      low_run_d = low_run_q + ONE_W;
    end

    case (state_q)
      ST_IDLE: begin
        if (START && !STOP) begin
          h_d      = h_clamp;
          l_d      = l_clamp;
          n_d      = NUM_PULSES;
          cnt_load = 1'b1;
          // The current IDLE cycle is itself low, hence the MIN_LOW-1 threshold
          if (low_run_q >= MIN_LOW_W - ONE_W) begin
            state_d = ST_HIGH;
            cnt_val = h_clamp - ONE_W;
            burst_d = ONE_W;
            pcnt_d  = pcnt_q + PCW'(1);
          end else begin
            state_d = ST_LOW;
            cnt_val = MIN_LOW_W - ONE_W - ONE_W - low_run_q;
            burst_d = '0;
          end
        end
      end
      ST_HIGH: begin
        if (STOP) begin
          state_d  = ST_GUARD;
          cnt_load = 1'b1;
          cnt_val  = MIN_LOW_W - ONE_W;
        end else if (cnt_zero) begin
          state_d  = ST_LOW;
          cnt_load = 1'b1;
          cnt_val  = l_q - ONE_W;
        end
      end
      ST_LOW: begin
        if (STOP) begin
          state_d  = ST_GUARD;
          cnt_load = 1'b1;
          cnt_val  = MIN_LOW_W - ONE_W;
        end else if (cnt_zero) begin
          if ((n_q != '0) && (burst_q == n_q)) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_HIGH;
            cnt_load = 1'b1;
            cnt_val  = h_q - ONE_W;
            // Saturating so continuous mode never matches a burst length by wrapping
            burst_d  = (burst_q == SAT_W) ? burst_q : burst_q + ONE_W;
            pcnt_d   = pcnt_q + PCW'(1);
          end
        end
      end
      ST_GUARD: begin
        if (cnt_zero) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      l_q       <= '0;
      n_q       <= '0;
      burst_q   <= '0;
      low_run_q <= '0;
      pcnt_q    <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      l_q       <= l_d;
      n_q       <= n_d;
      burst_q   <= burst_d;
      low_run_q <= low_run_d;
      pcnt_q    <= pcnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign OUT       = out_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PULSE_CNT = pcnt_q;

endmodule

// File: tb/tb_edge_pulse_generator_stacked.sv
// tb/tb_edge_pulse_generator_stacked.sv - directed self-checking bench for edge_pulse_generator_stacked
module tb_edge_pulse_generator_stacked;

  logic        clk = 1'b0;
  logic        resetb, start, stop, start_w, stop_w;
  logic [7:0]  high_cyc, low_cyc, num_pulses;
  logic        out, busy, done, out_w, busy_w, done_w;
  logic [15:0] pulse_cnt;
  logic [3:0]  pulse_cnt_w;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  edge_pulse_generator_stacked dut (
    .CLK(clk), .RESETB(resetb), .START(start), .STOP(stop),
    .HIGH_CYC(high_cyc), .LOW_CYC(low_cyc), .NUM_PULSES(num_pulses),
    .OUT(out), .BUSY(busy), .DONE(done), .PULSE_CNT(pulse_cnt)
  );

  edge_pulse_generator_stacked #(.PCW(4)) dut_w (
    .CLK(clk), .RESETB(resetb), .START(start_w), .STOP(stop_w),
    .HIGH_CYC(high_cyc), .LOW_CYC(low_cyc), .NUM_PULSES(num_pulses),
    .OUT(out_w), .BUSY(busy_w), .DONE(done_w), .PULSE_CNT(pulse_cnt_w)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetb = 1'b0; start = 1'b0; stop = 1'b0; start_w = 1'b0; stop_w = 1'b0;
    high_cyc = 8'd0; low_cyc = 8'd0; num_pulses = 8'd0;
    #3;
    checks++; if (out !== 1'b0) begin failures++; $display("FAIL reset_out: got %b expected 0", out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_status: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (pulse_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", pulse_cnt); end
    repeat (2) step();
    resetb = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0 || out !== 1'b0) begin failures++; $display("FAIL reset_idle: got busy=%b out=%b expected 0/0", busy, out); end
  endtask

  task automatic test_basic;
    logic [13:0] exp;
    exp = 14'b11100001110000;
    high_cyc = 8'd3; low_cyc = 8'd4; num_pulses = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    for (int i = 0; i < 14; i++) begin
      checks++; if (out !== exp[13-i]) begin failures++; $display("FAIL basic_out[%0d]: got %b expected %b", i, out, exp[13-i]); end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_fin: got done=%b busy=%b expected 1/1", done, busy); end
    checks++; if (pulse_cnt !== 16'd2) begin failures++; $display("FAIL basic_cnt: got %0d expected 2", pulse_cnt); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_clamp;
    int low_run;
    int det;
    low_run = 2; det = 0;
    high_cyc = 8'd0; low_cyc = 8'd1; num_pulses = 8'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (out !== ((i % 3) == 0)) begin failures++; $display("FAIL clamp_out[%0d]: got %b expected %b", i, out, ((i % 3) == 0)); end
      if (out === 1'b1) begin
        if (low_run >= 2) det++;
        low_run = 0;
      end else begin
        low_run++;
      end
      step();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL clamp_done: got %b expected 1", done); end
    checks++; if (det != 3) begin failures++; $display("FAIL clamp_detect: got %0d expected 3", det); end
    checks++; if (pulse_cnt !== 16'd5) begin failures++; $display("FAIL clamp_cnt: got %0d expected 5", pulse_cnt); end
    step();
  endtask

  task automatic test_stop;
    high_cyc = 8'd2; low_cyc = 8'd2; num_pulses = 8'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      checks++; if (out !== ((i % 4) < 2)) begin failures++; $display("FAIL stop_out[%0d]: got %b expected %b", i, out, ((i % 4) < 2)); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_early_done[%0d]: got %b expected 0", i, done); end
      if (i == 17) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    checks++; if (out !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stop_guard1: got out=%b busy=%b expected 0/1", out, busy); end
    step();
    checks++; if (out !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stop_guard2: got out=%b done=%b expected 0/0", out, done); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stop_done: got %b expected 1", done); end
    checks++; if (pulse_cnt !== 16'd10) begin failures++; $display("FAIL stop_cnt: got %0d expected 10", pulse_cnt); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int dones;
    int done_at;
    dones = 0; done_at = -1;
    high_cyc = 8'd1; low_cyc = 8'd2; num_pulses = 8'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        checks++; if (out !== ((i % 3) == 0)) begin failures++; $display("FAIL b2b_out[%0d]: got %b expected %b", i, out, ((i % 3) == 0)); end
      end
      if (done === 1'b1) begin dones++; done_at = i; end
      if (i == 2) begin start = 1'b1; num_pulses = 8'd5; high_cyc = 8'd4; end
      else start = 1'b0;
      step();
    end
    checks++; if (dones != 1 || done_at != 6) begin failures++; $display("FAIL b2b_done: got count=%0d at=%0d expected 1 at 6", dones, done_at); end
    checks++; if (pulse_cnt !== 16'd12) begin failures++; $display("FAIL b2b_cnt: got %0d expected 12", pulse_cnt); end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0 || out !== 1'b0) begin failures++; $display("FAIL startstop_idle: got busy=%b out=%b expected 0/0", busy, out); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL startstop_idle2: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_reset_mid;
    high_cyc = 8'd4; low_cyc = 8'd2; num_pulses = 8'd1;
    start = 1'b1; step(); start = 1'b0;
    step();
    checks++; if (out !== 1'b1) begin failures++; $display("FAIL rstmid_high: got %b expected 1", out); end
    #2 resetb = 1'b0;
    #1;
    checks++; if (out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_async: got out=%b busy=%b expected 0/0", out, busy); end
    checks++; if (pulse_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt: got %0d expected 0", pulse_cnt); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_nodone: got %b expected 0", done); end
    resetb = 1'b1;
    repeat (3) step();
    high_cyc = 8'd1; low_cyc = 8'd2; num_pulses = 8'd1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out !== (i == 0)) begin failures++; $display("FAIL rstmid_out[%0d]: got %b expected %b", i, out, (i == 0)); end
      step();
    end
    checks++; if (done !== 1'b1 || pulse_cnt !== 16'd1) begin failures++; $display("FAIL rstmid_fin: got done=%b cnt=%0d expected 1/1", done, pulse_cnt); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
  endtask

  task automatic test_wrap;
    logic [3:0] expw;
    logic found;
    found = 1'b0;
    high_cyc = 8'd1; low_cyc = 8'd2; num_pulses = 8'd0;
    start_w = 1'b1; step(); start_w = 1'b0;
    for (int i = 0; i < 51; i++) begin
      if ((i % 3) == 0) begin
        expw = 4'(i / 3 + 1);
        checks++; if (pulse_cnt_w !== expw) begin failures++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, pulse_cnt_w, expw); end
      end
      checks++; if (done_w !== 1'b0) begin failures++; $display("FAIL wrap_early_done[%0d]: got %b expected 0", i, done_w); end
      if (i == 50) stop_w = 1'b1;
      step();
    end
    stop_w = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done_w === 1'b1) found = 1'b1;
      step();
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL wrap_stop_done: got %b expected 1", found); end
    checks++; if (busy_w !== 1'b0 || pulse_cnt_w !== 4'd1) begin failures++; $display("FAIL wrap_end: got busy=%b cnt=%0d expected 0/1", busy_w, pulse_cnt_w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
